// File: rtl/nc_storage_pkg.sv
// Shared widths, line-word layout and packing helpers for the nC neighbour storage.
// Luma blocks are z-ordered 4x4 indices 0..15; chroma blocks are 0..3.
package nc_storage_pkg;

    localparam int MB_X_BITS     = 8;
    localparam int MB_Y_BITS     = 8;
    localparam int NC_LINE_WIDTH = 64;
    localparam int LINE_LUMA_LSB = 0;
    localparam int LINE_CB_LSB   = 32;
    localparam int LINE_CR_LSB   = 48;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACTIVE,
        ST_STORE
    } state_t;

    // Bottom row of the MB: luma 15,14,11,10 and chroma blocks 3,2, MSB first.
    function automatic logic [NC_LINE_WIDTH-1:0] pack_line(input logic [127:0] luma,
                                                           input logic [31:0]  cb,
                                                           input logic [31:0]  cr);
        return {cr[31:16], cb[31:16],
                luma[127:120], luma[119:112], luma[95:88], luma[87:80]};
    endfunction

    // Right column of the MB: luma 15,13,7,5 into bytes 3..0.
    function automatic logic [31:0] right_luma(input logic [127:0] luma);
        return {luma[127:120], luma[111:104], luma[63:56], luma[47:40]};
    endfunction

    // Right column of a chroma MB: blocks 3,1 into bytes 1..0.
    function automatic logic [15:0] right_chroma(input logic [31:0] c);
        return {c[31:24], c[15:8]};
    endfunction

endpackage

// File: rtl/nc_storage_line_ram.sv
// Line buffer holding the bottom-row TotalCoeff word of each MB column.
// Registered read; addresses at or beyond DEPTH never write and read back as 0.
module nc_storage_line_ram #(
    parameter int DEPTH = 120,
    parameter int WIDTH = 64,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = {1'b0, wr_addr} < LIMIT;
    assign rd_ok = {1'b0, rd_addr} < LIMIT;

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= rd_ok ? mem[rd_addr[IW-1:0]] : '0;
        end
    end

endmodule

// File: rtl/nc_storage.sv
// Writer side of the nC neighbour interface: collects per-block TotalCoeff for the
// current MB and presents up/left/curr buses in the layout nC_decoding expects.
//
// state  | meaning
// IDLE   | waiting for mb_start_in; line read issued on the start cycle
// LOAD   | line-buffer data arrives; up/left buses settle
// ACTIVE | buses valid, write strobes accepted
// STORE  | bottom row to line buffer, right column to left buses
module nc_storage
    import nc_storage_pkg::*;
#(
    parameter int LINE_DEPTH = 120
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MB_X_BITS-1:0] mb_x_in,
    input  logic [MB_Y_BITS-1:0] mb_y_in,
    input  logic                 mb_start_in,
    input  logic                 mb_end_in,
    input  logic                 luma_wr_in,
    input  logic [3:0]           luma4x4BlkIdx_in,
    input  logic                 chroma_cb_wr_in,
    input  logic                 chroma_cr_wr_in,
    input  logic [1:0]           chroma4x4BlkIdx_in,
    input  logic [4:0]           total_coeff_in,
    output logic                 ready_out,
    output logic                 mb_done_out,
    output logic [31:0]          nC_up_mb_out,
    output logic [31:0]          nC_left_mb_out,
    output logic [127:0]         nC_curr_mb_out,
    output logic [15:0]          nC_cb_up_mb_out,
    output logic [15:0]          nC_cb_left_mb_out,
    output logic [31:0]          nC_cb_curr_mb_out,
    output logic [15:0]          nC_cr_up_mb_out,
    output logic [15:0]          nC_cr_left_mb_out,
    output logic [31:0]          nC_cr_curr_mb_out
);

    state_t                   state;
    logic [MB_X_BITS-1:0]     mb_x;
    logic [MB_Y_BITS-1:0]     mb_y;
    logic                     line_rd_en;
    logic                     line_wr_en;
    logic [NC_LINE_WIDTH-1:0] line_rd;
    logic [NC_LINE_WIDTH-1:0] line_wr;

    assign line_rd_en = (state == ST_IDLE) && mb_start_in;
    assign line_wr_en = (state == ST_STORE);
    assign line_wr    = pack_line(nC_curr_mb_out, nC_cb_curr_mb_out, nC_cr_curr_mb_out);

    nc_storage_line_ram #(
        .DEPTH (LINE_DEPTH),
        .WIDTH (NC_LINE_WIDTH),
        .AW    (MB_X_BITS)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (line_wr_en),
        .wr_addr (mb_x),
        .wr_data (line_wr),
        .rd_en   (line_rd_en),
        .rd_addr (mb_x_in),
        .rd_data (line_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            mb_x              <= '0;
            mb_y              <= '0;
            ready_out         <= 1'b0;
            mb_done_out       <= 1'b0;
            nC_up_mb_out      <= '0;
            nC_left_mb_out    <= '0;
            nC_curr_mb_out    <= '0;
            nC_cb_up_mb_out   <= '0;
            nC_cb_left_mb_out <= '0;
            nC_cb_curr_mb_out <= '0;
            nC_cr_up_mb_out   <= '0;
            nC_cr_left_mb_out <= '0;
            nC_cr_curr_mb_out <= '0;
        end else begin
            mb_done_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mb_start_in) begin
                        mb_x              <= mb_x_in;
                        mb_y              <= mb_y_in;
                        nC_curr_mb_out    <= '0;
                        nC_cb_curr_mb_out <= '0;
                        nC_cr_curr_mb_out <= '0;
                        state             <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (mb_y == '0) begin
                        nC_up_mb_out    <= '0;
                        nC_cb_up_mb_out <= '0;
                        nC_cr_up_mb_out <= '0;
                    end else begin
                        nC_up_mb_out    <= line_rd[LINE_LUMA_LSB +: 32];
                        nC_cb_up_mb_out <= line_rd[LINE_CB_LSB +: 16];
                        nC_cr_up_mb_out <= line_rd[LINE_CR_LSB +: 16];
                    end
                    // First column of a row has no left neighbour.
                    if (mb_x == '0) begin
                        nC_left_mb_out    <= '0;
                        nC_cb_left_mb_out <= '0;
                        nC_cr_left_mb_out <= '0;
                    end
                    ready_out <= 1'b1;
                    state     <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (luma_wr_in) begin
                        nC_curr_mb_out[{luma4x4BlkIdx_in, 3'b000} +: 8] <= {3'b000, total_coeff_in};
                    end
                    if (chroma_cb_wr_in) begin
                        nC_cb_curr_mb_out[{chroma4x4BlkIdx_in, 3'b000} +: 8] <= {3'b000, total_coeff_in};
                    end
                    if (chroma_cr_wr_in) begin
                        nC_cr_curr_mb_out[{chroma4x4BlkIdx_in, 3'b000} +: 8] <= {3'b000, total_coeff_in};
                    end
                    if (mb_end_in) begin
                        ready_out <= 1'b0;
                        state     <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    nC_left_mb_out    <= right_luma(nC_curr_mb_out);
                    nC_cb_left_mb_out <= right_chroma(nC_cb_curr_mb_out);
                    nC_cr_left_mb_out <= right_chroma(nC_cr_curr_mb_out);
                    mb_done_out       <= 1'b1;
                    state             <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nc_storage.sv
// Randomised bench for nc_storage against a per-block array model of the
// current MB, the line of bottom rows above and the left right-column.
module tb_nc_storage;

    localparam int DEPTH = 120;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   mb_x_in = '0;
    logic [7:0]   mb_y_in = '0;
    logic         mb_start_in = 1'b0;
    logic         mb_end_in = 1'b0;
    logic         luma_wr_in = 1'b0;
    logic [3:0]   luma4x4BlkIdx_in = '0;
    logic         chroma_cb_wr_in = 1'b0;
    logic         chroma_cr_wr_in = 1'b0;
    logic [1:0]   chroma4x4BlkIdx_in = '0;
    logic [4:0]   total_coeff_in = '0;
    logic         ready_out;
    logic         mb_done_out;
    logic [31:0]  nC_up_mb_out;
    logic [31:0]  nC_left_mb_out;
    logic [127:0] nC_curr_mb_out;
    logic [15:0]  nC_cb_up_mb_out;
    logic [15:0]  nC_cb_left_mb_out;
    logic [31:0]  nC_cb_curr_mb_out;
    logic [15:0]  nC_cr_up_mb_out;
    logic [15:0]  nC_cr_left_mb_out;
    logic [31:0]  nC_cr_curr_mb_out;

    nc_storage #(.LINE_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .mb_x_in            (mb_x_in),
        .mb_y_in            (mb_y_in),
        .mb_start_in        (mb_start_in),
        .mb_end_in          (mb_end_in),
        .luma_wr_in         (luma_wr_in),
        .luma4x4BlkIdx_in   (luma4x4BlkIdx_in),
        .chroma_cb_wr_in    (chroma_cb_wr_in),
        .chroma_cr_wr_in    (chroma_cr_wr_in),
        .chroma4x4BlkIdx_in (chroma4x4BlkIdx_in),
        .total_coeff_in     (total_coeff_in),
        .ready_out          (ready_out),
        .mb_done_out        (mb_done_out),
        .nC_up_mb_out       (nC_up_mb_out),
        .nC_left_mb_out     (nC_left_mb_out),
        .nC_curr_mb_out     (nC_curr_mb_out),
        .nC_cb_up_mb_out    (nC_cb_up_mb_out),
        .nC_cb_left_mb_out  (nC_cb_left_mb_out),
        .nC_cb_curr_mb_out  (nC_cb_curr_mb_out),
        .nC_cr_up_mb_out    (nC_cr_up_mb_out),
        .nC_cr_left_mb_out  (nC_cr_left_mb_out),
        .nC_cr_curr_mb_out  (nC_cr_curr_mb_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Block positions by geometry: bottom row x=0..3, right column y=0..3.
    int BOT[4]   = '{10, 11, 14, 15};
    int RIGHT[4] = '{5, 7, 13, 15};
    int CBOT[2]  = '{2, 3};
    int CRIGHT[2] = '{1, 3};

    logic [4:0] m_luma[16];
    logic [4:0] m_cb[4];
    logic [4:0] m_cr[4];
    logic [4:0] l_luma[DEPTH][4];
    logic [4:0] l_cb[DEPTH][2];
    logic [4:0] l_cr[DEPTH][2];
    logic [4:0] left_luma[4];
    logic [4:0] left_cb[2];
    logic [4:0] left_cr[2];
    int cur_x, cur_y;

    task automatic check_curr(input string tag);
        logic [127:0] el;
        logic [31:0]  ecb, ecr;
        el = '0; ecb = '0; ecr = '0;
        for (int k = 0; k < 16; k++) el[k*8 +: 8] = {3'b000, m_luma[k]};
        for (int k = 0; k < 4; k++) begin
            ecb[k*8 +: 8] = {3'b000, m_cb[k]};
            ecr[k*8 +: 8] = {3'b000, m_cr[k]};
        end
        chk({tag, "_curr"}, nC_curr_mb_out, el);
        chk({tag, "_cb_curr"}, nC_cb_curr_mb_out, ecb);
        chk({tag, "_cr_curr"}, nC_cr_curr_mb_out, ecr);
    endtask

    task automatic check_neigh(input string tag);
        logic [31:0] eu, el;
        logic [15:0] ecbu, ecru, ecbl, ecrl;
        eu = '0; el = '0; ecbu = '0; ecru = '0; ecbl = '0; ecrl = '0;
        if (cur_y != 0 && cur_x < DEPTH) begin
            for (int i = 0; i < 4; i++) eu[i*8 +: 8] = {3'b000, l_luma[cur_x][i]};
            for (int i = 0; i < 2; i++) begin
                ecbu[i*8 +: 8] = {3'b000, l_cb[cur_x][i]};
                ecru[i*8 +: 8] = {3'b000, l_cr[cur_x][i]};
            end
        end
        if (cur_x != 0) begin
            for (int j = 0; j < 4; j++) el[j*8 +: 8] = {3'b000, left_luma[j]};
            for (int j = 0; j < 2; j++) begin
                ecbl[j*8 +: 8] = {3'b000, left_cb[j]};
                ecrl[j*8 +: 8] = {3'b000, left_cr[j]};
            end
        end
        chk({tag, "_up"}, nC_up_mb_out, eu);
        chk({tag, "_cb_up"}, nC_cb_up_mb_out, ecbu);
        chk({tag, "_cr_up"}, nC_cr_up_mb_out, ecru);
        chk({tag, "_left"}, nC_left_mb_out, el);
        chk({tag, "_cb_left"}, nC_cb_left_mb_out, ecbl);
        chk({tag, "_cr_left"}, nC_cr_left_mb_out, ecrl);
    endtask

    task automatic clear_inputs();
        mb_start_in = 1'b0; mb_end_in = 1'b0;
        luma_wr_in = 1'b0; chroma_cb_wr_in = 1'b0; chroma_cr_wr_in = 1'b0;
    endtask

    // Entered and left just after a negedge.
    task automatic do_mb(input int x, input int y);
        mb_x_in = 8'(x); mb_y_in = 8'(y); mb_start_in = 1'b1;
        luma_wr_in = 1'b1; luma4x4BlkIdx_in = 4'($urandom_range(0, 15));
        chroma_cb_wr_in = 1'b1; chroma4x4BlkIdx_in = 2'($urandom_range(0, 3));
        total_coeff_in = 5'($urandom_range(1, 16));
        @(posedge clk); @(negedge clk);
        mb_start_in = 1'b0;
        cur_x = x; cur_y = y;
        for (int k = 0; k < 16; k++) m_luma[k] = '0;
        for (int k = 0; k < 4; k++) begin m_cb[k] = '0; m_cr[k] = '0; end
        chk("load_ready", {127'b0, ready_out}, 128'd0);
        chk("load_done", {127'b0, mb_done_out}, 128'd0);
        luma_wr_in = 1'b1; chroma_cr_wr_in = 1'b1; mb_end_in = 1'b1;
        total_coeff_in = 5'($urandom_range(1, 16));
        @(posedge clk); @(negedge clk);
        clear_inputs();
        chk("active_ready", {127'b0, ready_out}, 128'd1);
        check_curr("start");
        check_neigh("start");
    endtask

    task automatic wr(input logic lw, input logic [3:0] li, input logic cbw, input logic crw,
                      input logic [1:0] ci, input logic [4:0] tc, input logic last,
                      input logic stray);
        luma_wr_in = lw; luma4x4BlkIdx_in = li;
        chroma_cb_wr_in = cbw; chroma_cr_wr_in = crw; chroma4x4BlkIdx_in = ci;
        total_coeff_in = tc; mb_end_in = last; mb_start_in = stray;
        mb_x_in = 8'($urandom_range(0, 255)); mb_y_in = 8'($urandom_range(0, 255));
        @(posedge clk);
        if (lw) m_luma[li] = tc;
        if (cbw) m_cb[ci] = tc;
        if (crw) m_cr[ci] = tc;
        @(negedge clk);
        clear_inputs();
        chk("wr_ready", {127'b0, ready_out}, {127'b0, !last});
        check_curr("wr");
    endtask

    task automatic rand_writes(input int n);
        for (int i = 0; i < n; i++) begin
            wr(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
               5'($urandom_range(0, 31)), 1'b0, ($urandom_range(0, 7) == 0));
        end
    endtask

    task automatic rand_last();
        wr(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
           5'($urandom_range(0, 31)), 1'b1, 1'b0);
    endtask

    // Entered at the STORE-cycle negedge; returns at the first IDLE negedge.
    task automatic finish_mb();
        @(posedge clk); @(negedge clk);
        chk("done_pulse", {127'b0, mb_done_out}, 128'd1);
        chk("done_ready", {127'b0, ready_out}, 128'd0);
        check_curr("retain");
        if (cur_x < DEPTH) begin
            for (int i = 0; i < 4; i++) l_luma[cur_x][i] = m_luma[BOT[i]];
            for (int i = 0; i < 2; i++) begin
                l_cb[cur_x][i] = m_cb[CBOT[i]];
                l_cr[cur_x][i] = m_cr[CBOT[i]];
            end
        end
        for (int j = 0; j < 4; j++) left_luma[j] = m_luma[RIGHT[j]];
        for (int j = 0; j < 2; j++) begin
            left_cb[j] = m_cb[CRIGHT[j]];
            left_cr[j] = m_cr[CRIGHT[j]];
        end
    endtask

    task automatic rand_mb(input int x, input int y);
        do_mb(x, y);
        rand_writes($urandom_range(0, 5));
        rand_last();
        finish_mb();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) m_luma[k] = '0;
        for (int k = 0; k < 4; k++) begin m_cb[k] = '0; m_cr[k] = '0; left_luma[k] = '0; end
        for (int k = 0; k < 2; k++) begin left_cb[k] = '0; left_cr[k] = '0; end
        cur_x = 0; cur_y = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {127'b0, ready_out}, 128'd0);
        chk("rst_done", {127'b0, mb_done_out}, 128'd0);
        check_curr("rst");
        check_neigh("rst");

        // Strobes while IDLE must not touch anything.
        luma_wr_in = 1'b1; luma4x4BlkIdx_in = 4'd3; chroma_cb_wr_in = 1'b1;
        chroma_cr_wr_in = 1'b1; chroma4x4BlkIdx_in = 2'd1; total_coeff_in = 5'd9; mb_end_in = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        chk("idle_ready", {127'b0, ready_out}, 128'd0);
        chk("idle_done", {127'b0, mb_done_out}, 128'd0);
        check_curr("idle");

        // MB (0,0): directed contents.
        do_mb(0, 0);
        wr(1'b1, 4'd5,  1'b0, 1'b0, 2'd0, 5'd3,  1'b0, 1'b0);
        wr(1'b1, 4'd15, 1'b0, 1'b0, 2'd0, 5'd16, 1'b0, 1'b0);
        wr(1'b0, 4'd0,  1'b1, 1'b0, 2'd1, 5'd2,  1'b0, 1'b0);
        wr(1'b1, 4'd10, 1'b0, 1'b0, 2'd0, 5'd7,  1'b0, 1'b1);
        wr(1'b1, 4'd14, 1'b0, 1'b0, 2'd0, 5'd9,  1'b0, 1'b0);
        wr(1'b0, 4'd0,  1'b0, 1'b1, 2'd3, 5'd4,  1'b1, 1'b0);
        finish_mb();

        // MB (1,0): left picks up the previous right column.
        do_mb(1, 0);
        chk("x1_left_const", {96'b0, nC_left_mb_out}, 128'h10000003);
        chk("x1_cb_left_const", {112'b0, nC_cb_left_mb_out}, 128'h0002);
        wr(1'b1, 4'd0, 1'b1, 1'b1, 2'd0, 5'd6, 1'b0, 1'b0);
        chk("simul_bytes", {104'b0, nC_curr_mb_out[7:0], nC_cb_curr_mb_out[7:0], nC_cr_curr_mb_out[7:0]},
            128'h060606);
        rand_writes(3);
        rand_last();
        finish_mb();

        // MB (2,0): write coinciding with mb_end must be stored.
        do_mb(2, 0);
        rand_writes(2);
        wr(1'b1, 4'd11, 1'b0, 1'b0, 2'd0, 5'd5, 1'b1, 1'b0);
        finish_mb();
        rand_mb(3, 0);

        for (int y = 1; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                do_mb(x, y);
                if (y == 1 && x == 0) begin
                    chk("row_wrap_up", {96'b0, nC_up_mb_out}, 128'h10090007);
                    chk("row_wrap_cr_up", {112'b0, nC_cr_up_mb_out}, 128'h0400);
                    chk("row_wrap_left", {96'b0, nC_left_mb_out}, 128'h0);
                end
                if (y == 1 && x == 2) begin
                    chk("end_write_up_b1", {120'b0, nC_up_mb_out[15:8]}, 128'h5);
                end
                rand_writes($urandom_range(0, 5));
                rand_last();
                finish_mb();
            end
            rand_mb(200, y);
        end

        // Reset in the middle of ACTIVE.
        do_mb(1, 3);
        rand_writes(2);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst_ready", {127'b0, ready_out}, 128'd0);
        chk("midrst_done", {127'b0, mb_done_out}, 128'd0);
        for (int k = 0; k < 16; k++) m_luma[k] = '0;
        for (int k = 0; k < 4; k++) begin m_cb[k] = '0; m_cr[k] = '0; left_luma[k] = '0; end
        for (int k = 0; k < 2; k++) begin left_cb[k] = '0; left_cr[k] = '0; end
        check_curr("midrst");
        chk("midrst_up", {96'b0, nC_up_mb_out}, 128'h0);
        chk("midrst_left", {96'b0, nC_left_mb_out}, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        rand_mb(3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
